// File: rtl/vram_write_arbiter_pkg.sv
// Shared widths, FSM states and payload types for the VRAM write arbiter.
package vram_write_arbiter_pkg;

    localparam int unsigned ROW_W  = 6;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned RGB_W  = 3;
    localparam int unsigned ROWS   = 60;
    localparam int unsigned COLS   = 80;
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fillState_t;

    // One VRAM write-port beat.
    typedef struct packed {
        logic              writeEnable;
        logic [ADDR_W-1:0] address;
        logic [RGB_W-1:0]  data;
    } vramWrite_t;

    // Rectangle bounds kept for the duration of a fill (row0 only seeds the cursor).
    typedef struct packed {
        logic [COL_W-1:0] col0;
        logic [COL_W-1:0] col1;
        logic [ROW_W-1:0] row1;
        logic [RGB_W-1:0] rgb;
    } fillBounds_t;

    // Rectangle must be ordered and lie entirely on screen.
    function automatic logic rectValid(
        input logic [ROW_W-1:0] row0,
        input logic [COL_W-1:0] col0,
        input logic [ROW_W-1:0] row1,
        input logic [COL_W-1:0] col1
    );
        return (row0 <= row1) && (col0 <= col1) &&
               (row1 < ROW_W'(ROWS)) && (col1 < COL_W'(COLS));
    endfunction

endpackage

// File: rtl/vram_fill_cursor.sv
// Raster cursor for the fill engine: loads a start point, steps left-to-right,
// top-to-bottom within the latched bounds, and parks on the last pixel.
module vram_fill_cursor
    import vram_write_arbiter_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             advance,
    input  logic [ROW_W-1:0] loadRow,
    input  logic [COL_W-1:0] loadCol,
    input  logic [COL_W-1:0] col0,
    input  logic [COL_W-1:0] col1,
    input  logic [ROW_W-1:0] row1,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             lastPixel_c
);

    assign lastPixel_c = (row == row1) && (col == col1);

    // Cursor register; never steps past (row1, col1) so the row cannot wrap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= loadRow;
            col <= loadCol;
        end else if (advance && !lastPixel_c) begin
            if (col == col1) begin
                col <= col0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Owns the VRAM write port: CPU pixel writes take priority over the
// rectangle-fill engine, which holds its cursor while the CPU writes.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCpuWriteEnable,
    input  logic [ROW_W-1:0]  iCpuRow,
    input  logic [COL_W-1:0]  iCpuCol,
    input  logic [RGB_W-1:0]  iCpuRGB,
    input  logic              iFillStart,
    input  logic [ROW_W-1:0]  iFillRow0,
    input  logic [COL_W-1:0]  iFillCol0,
    input  logic [ROW_W-1:0]  iFillRow1,
    input  logic [COL_W-1:0]  iFillCol1,
    input  logic [RGB_W-1:0]  iFillRGB,
    output logic              oFillBusy,
    output logic              oFillDone,
    output logic              oFillError,
    output logic              oVramWriteEnable,
    output logic [ADDR_W-1:0] oVramWriteAddress,
    output logic [RGB_W-1:0]  oVramDataIn
);

    fillState_t  state, stateNext;
    fillBounds_t bounds;
    vramWrite_t  writeReg, writeNext;
    logic        busyReg, doneReg, errorReg, errorNext;
    logic        boundsLoad, cursorLoad, cursorAdvance;
    logic [ROW_W-1:0] cursorRow;
    logic [COL_W-1:0] cursorCol;
    logic        lastPixel_c;

    vram_fill_cursor u_cursor (
        .Clock       (Clock),
        .Reset       (Reset),
        .load        (cursorLoad),
        .advance     (cursorAdvance),
        .loadRow     (iFillRow0),
        .loadCol     (iFillCol0),
        .col0        (bounds.col0),
        .col1        (bounds.col1),
        .row1        (bounds.row1),
        .row         (cursorRow),
        .col         (cursorCol),
        .lastPixel_c (lastPixel_c)
    );

    // FSM state register; reset aborts any fill in progress.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= FILL_IDLE;
        else       state <= stateNext;
    end

    // Next state, arbitration and next output values.
    always_comb begin
        stateNext     = state;
        writeNext     = '0;
        errorNext     = 1'b0;
        boundsLoad    = 1'b0;
        cursorLoad    = 1'b0;
        cursorAdvance = 1'b0;

        if (iCpuWriteEnable) begin
            writeNext.writeEnable = 1'b1;
            writeNext.address     = {iCpuRow, iCpuCol};
            writeNext.data        = iCpuRGB;
        end

        unique case (state)
            FILL_IDLE: begin
                if (iFillStart) begin
                    if (rectValid(iFillRow0, iFillCol0, iFillRow1, iFillCol1)) begin
                        boundsLoad = 1'b1;
                        cursorLoad = 1'b1;
                        stateNext  = FILL_RUN;
                    end else begin
                        errorNext = 1'b1;
                    end
                end
            end
            FILL_RUN: begin
                if (!iCpuWriteEnable) begin
                    writeNext.writeEnable = 1'b1;
                    writeNext.address     = {cursorRow, cursorCol};
                    writeNext.data        = bounds.rgb;
                    cursorAdvance         = 1'b1;
                    if (lastPixel_c) stateNext = FILL_DONE;
                end
            end
            FILL_DONE: stateNext = FILL_IDLE;
            default:   stateNext = FILL_IDLE;
        endcase
    end

    // Output and rectangle-bound registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            writeReg <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
            errorReg <= 1'b0;
            bounds   <= '0;
        end else begin
            writeReg <= writeNext;
            busyReg  <= (stateNext == FILL_RUN);
            doneReg  <= (state == FILL_DONE);
            errorReg <= errorNext;
            if (boundsLoad) begin
                bounds.col0 <= iFillCol0;
                bounds.col1 <= iFillCol1;
                bounds.row1 <= iFillRow1;
                bounds.rgb  <= iFillRGB;
            end
        end
    end

    assign oFillBusy         = busyReg;
    assign oFillDone         = doneReg;
    assign oFillError        = errorReg;
    assign oVramWriteEnable  = writeReg.writeEnable;
    assign oVramWriteAddress = writeReg.address;
    assign oVramDataIn       = writeReg.data;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: reset abort, fills with and without
// CPU interleave, bad rectangles, single pixel, and full-screen clear.
module tb_vram_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iCpuWriteEnable;
    logic [5:0]  iCpuRow;
    logic [6:0]  iCpuCol;
    logic [2:0]  iCpuRGB;
    logic        iFillStart;
    logic [5:0]  iFillRow0, iFillRow1;
    logic [6:0]  iFillCol0, iFillCol1;
    logic [2:0]  iFillRGB;
    logic        oFillBusy, oFillDone, oFillError, oVramWriteEnable;
    logic [12:0] oVramWriteAddress;
    logic [2:0]  oVramDataIn;

    int testsRun = 0;
    int testsFailed = 0;

    int wq[$];
    int eq[$];
    int doneCount, errorCount, lastWriteCycle, doneCycle;

    vram_write_arbiter dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iCpuWriteEnable   (iCpuWriteEnable),
        .iCpuRow           (iCpuRow),
        .iCpuCol           (iCpuCol),
        .iCpuRGB           (iCpuRGB),
        .iFillStart        (iFillStart),
        .iFillRow0         (iFillRow0),
        .iFillCol0         (iFillCol0),
        .iFillRow1         (iFillRow1),
        .iFillCol1         (iFillCol1),
        .iFillRGB          (iFillRGB),
        .oFillBusy         (oFillBusy),
        .oFillDone         (oFillDone),
        .oFillError        (oFillError),
        .oVramWriteEnable  (oVramWriteEnable),
        .oVramWriteAddress (oVramWriteAddress),
        .oVramDataIn       (oVramDataIn)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic int packWrite(input int r, input int c, input int rgb);
        return (((r << 7) | c) << 3) | rgb;
    endfunction

    task automatic startFill(input int r0, input int c0, input int r1, input int c1, input int rgb);
        iFillStart = 1'b1;
        iFillRow0 = 6'(r0); iFillCol0 = 7'(c0);
        iFillRow1 = 6'(r1); iFillCol1 = 7'(c1);
        iFillRGB  = 3'(rgb);
        tick;
        iFillStart = 1'b0;
    endtask

    // Clock the DUT until done plus a few trailing cycles, logging every write.
    // cpuAt injects CPU write (10,10,3'b010) at that cycle; startAt injects a stray start.
    task automatic collect(input int cpuAt, input int startAt, input int maxCycles);
        int extra;
        bit finished;
        extra = 0;
        finished = 1'b0;
        wq.delete();
        doneCount = 0; errorCount = 0; lastWriteCycle = -1; doneCycle = -1;
        for (int i = 0; i < maxCycles && extra < 4; i++) begin
            if (i == cpuAt) begin
                iCpuWriteEnable = 1'b1; iCpuRow = 6'd10; iCpuCol = 7'd10; iCpuRGB = 3'b010;
            end
            if (i == startAt) begin
                iFillStart = 1'b1; iFillRow0 = 6'd0; iFillCol0 = 7'd0;
                iFillRow1 = 6'd0; iFillCol1 = 7'd0; iFillRGB = 3'b001;
            end
            tick;
            iCpuWriteEnable = 1'b0;
            iFillStart = 1'b0;
            if (oVramWriteEnable) begin
                wq.push_back(32'({oVramWriteAddress, oVramDataIn}));
                lastWriteCycle = i;
            end
            if (oFillDone) begin
                doneCount++;
                doneCycle = i;
                finished = 1'b1;
            end
            if (oFillError) errorCount++;
            if (finished) extra++;
        end
        checkValue("fill_terminates", 32'(finished), 32'd1);
    endtask

    task automatic buildExpect(input int r0, input int c0, input int r1, input int c1,
                               input int rgb, input int cpuAt);
        int idx;
        idx = 0;
        eq.delete();
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                if (idx == cpuAt) begin
                    eq.push_back(packWrite(10, 10, 2));
                    idx++;
                end
                eq.push_back(packWrite(r, c, rgb));
                idx++;
            end
        end
    endtask

    task automatic compareWrites(input string tag);
        checkValue({tag, "_write_count"}, 32'(wq.size()), 32'(eq.size()));
        for (int k = 0; k < eq.size() && k < wq.size(); k++)
            checkValue($sformatf("%s_w%0d", tag, k), wq[k], eq[k]);
    endtask

    task automatic badStart(input string tag, input int r0, input int c0, input int r1, input int c1);
        startFill(r0, c0, r1, c1, 3);
        checkValue({tag, "_error"}, 32'(oFillError), 32'd1);
        checkValue({tag, "_busy"}, 32'(oFillBusy), 32'd0);
        checkValue({tag, "_we"}, 32'(oVramWriteEnable), 32'd0);
        tick;
        checkValue({tag, "_error_clear"}, 32'(oFillError), 32'd0);
        checkValue({tag, "_we_after"}, 32'(oVramWriteEnable), 32'd0);
    endtask

    initial begin
        int writes;
        bit hit [4800];
        int dups, bad, hits;

        Reset = 1'b1;
        iCpuWriteEnable = 1'b0; iCpuRow = '0; iCpuCol = '0; iCpuRGB = '0;
        iFillStart = 1'b0; iFillRow0 = '0; iFillCol0 = '0;
        iFillRow1 = '0; iFillCol1 = '0; iFillRGB = '0;
        tick; tick;
        checkValue("reset_outputs",
                   32'({oFillBusy, oFillDone, oFillError, oVramWriteEnable, oVramWriteAddress, oVramDataIn}), 32'd0);
        Reset = 1'b0;
        tick;

        // 1: reset mid-fill aborts the fill
        startFill(0, 0, 59, 79, 1);
        for (int i = 0; i < 10; i++) tick;
        checkValue("t1_busy_before_reset", 32'(oFillBusy), 32'd1);
        Reset = 1'b1;
        tick;
        checkValue("t1_outputs_after_reset",
                   32'({oFillBusy, oFillDone, oFillError, oVramWriteEnable, oVramWriteAddress, oVramDataIn}), 32'd0);
        Reset = 1'b0;
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (oVramWriteEnable || oFillBusy || oFillDone) writes++;
        end
        checkValue("t1_no_activity_after_release", 32'(writes), 32'd0);

        // 2: plain 2x3 fill, stray start mid-fill ignored
        startFill(2, 3, 3, 5, 3'b101);
        checkValue("t2_busy", 32'(oFillBusy), 32'd1);
        checkValue("t2_no_write_yet", 32'(oVramWriteEnable), 32'd0);
        collect(-1, 3, 40);
        buildExpect(2, 3, 3, 5, 3'b101, -1);
        compareWrites("t2");
        checkValue("t2_done_count", 32'(doneCount), 32'd1);
        checkValue("t2_done_cycle", 32'(doneCycle), 32'd6);
        checkValue("t2_done_after_last", 32'(doneCycle), 32'(lastWriteCycle + 1));
        checkValue("t2_no_error", 32'(errorCount), 32'd0);

        // 3: same fill with one CPU write stolen on the third fill cycle
        startFill(2, 3, 3, 5, 3'b101);
        collect(2, -1, 40);
        buildExpect(2, 3, 3, 5, 3'b101, 2);
        compareWrites("t3");
        checkValue("t3_last_write_cycle", 32'(lastWriteCycle), 32'd6);
        checkValue("t3_done_cycle", 32'(doneCycle), 32'd7);

        // 4: bad rectangles
        badStart("t4_row_order", 5, 0, 4, 0);
        badStart("t4_col_range", 0, 0, 0, 80);
        badStart("t4_row_range", 0, 0, 60, 0);

        // 5: single pixel at the far corner, start during DONE ignored
        startFill(59, 79, 59, 79, 3'b111);
        collect(-1, 1, 20);
        buildExpect(59, 79, 59, 79, 3'b111, -1);
        compareWrites("t5");
        checkValue("t5_done_cycle", 32'(doneCycle), 32'd1);
        checkValue("t5_done_count", 32'(doneCount), 32'd1);
        checkValue("t5_no_error", 32'(errorCount), 32'd0);
        checkValue("t5_idle_after", 32'(oFillBusy), 32'd0);

        // 7: CPU write and start together in IDLE
        iCpuWriteEnable = 1'b1; iCpuRow = 6'd1; iCpuCol = 7'd2; iCpuRGB = 3'b011;
        startFill(0, 0, 0, 1, 3'b100);
        iCpuWriteEnable = 1'b0;
        checkValue("t7_cpu_write", 32'({oVramWriteEnable, oVramWriteAddress, oVramDataIn}),
                   32'((1 << 16) | packWrite(1, 2, 3)));
        checkValue("t7_busy", 32'(oFillBusy), 32'd1);
        collect(-1, -1, 20);
        buildExpect(0, 0, 0, 1, 3'b100, -1);
        compareWrites("t7");

        // 6: full-screen clear with address scoreboard
        startFill(0, 0, 59, 79, 3'b110);
        collect(-1, -1, 6000);
        dups = 0; bad = 0; hits = 0;
        foreach (wq[k]) begin
            int col, row;
            col = (wq[k] >> 3) & 32'h7f;
            row = (wq[k] >> 10) & 32'h3f;
            if (row >= 60 || col >= 80 || (wq[k] & 7) != 6) bad++;
            else if (hit[row * 80 + col]) dups++;
            else begin
                hit[row * 80 + col] = 1'b1;
                hits++;
            end
        end
        checkValue("t6_write_count", 32'(wq.size()), 32'd4800);
        checkValue("t6_unique_hits", 32'(hits), 32'd4800);
        checkValue("t6_duplicates", 32'(dups), 32'd0);
        checkValue("t6_bad_writes", 32'(bad), 32'd0);
        checkValue("t6_done_count", 32'(doneCount), 32'd1);
        checkValue("t6_done_after_last", 32'(doneCycle), 32'(lastWriteCycle + 1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
